cpwm_multich: RTL and testbench

Multi-channel carrier PWM generator: one shared prescaled carrier counter drives `N_CH` compare channels, each producing a complementary high/low pair with programmable dead time. Compare and period values are double-buffered and reloaded at mask-selected carrier extremes. Interrupts are raised every programmable number of reload events. It sits behind the AXI4-Lite register block of the CPWM IP and uses the count, mask, PWM on/off and interrupt on/off encodings from `PKG_pwm`.

---
 rtl/cpwm_multich.sv | 222 ++++++++++++++++++++++
 tb/tb_cpwm_multich.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpwm_multich.sv
// Multi-channel carrier PWM: shared prescaled carrier, double-buffered period/compare,
// complementary outputs, reload-event interrupt divider. CPWM_DEADTIME_EN adds dead-time counters.
module cpwm_multich #(
  parameter int N_CH           = 3,
  parameter int DIVCLK_WIDTH   = 5,
  parameter int PWMCOUNT_WIDTH = 16,
  parameter int DTCOUNT_WIDTH  = 8,
  parameter int INTCOUNT_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pwm_on,
  input  logic                           int_on,
  input  logic [1:0]                     count_mode,
  input  logic [1:0]                     mask_mode,
  input  logic [DIVCLK_WIDTH-1:0]        clkdiv,
  input  logic [PWMCOUNT_WIDTH-1:0]      period,
  input  logic [N_CH*PWMCOUNT_WIDTH-1:0] compare,
  input  logic [DTCOUNT_WIDTH-1:0]       deadtime,
  input  logic [INTCOUNT_WIDTH-1:0]      int_count,
  output logic [PWMCOUNT_WIDTH-1:0]      carrier,
  output logic [N_CH-1:0]                pwm_h,
  output logic [N_CH-1:0]                pwm_l,
  output logic                           load_evt,
  output logic                           irq
);
  localparam int W = PWMCOUNT_WIDTH;

  localparam logic [1:0] COUNT_UP     = 2'b00;
  localparam logic [1:0] COUNT_DOWN   = 2'b01;
  localparam logic [1:0] COUNT_UPDOWN = 2'b10;
  localparam logic [1:0] NO_MASK      = 2'b00;
  localparam logic [1:0] MIN_MASK     = 2'b01;
  localparam logic [1:0] MAX_MASK     = 2'b10;
  localparam logic [1:0] MINMAX_MASK  = 2'b11;
  localparam logic       PWM_ON       = 1'b1;
  localparam logic       INT_ON       = 1'b1;

  localparam logic [W-1:0]              C_ONE = W'(1);
  localparam logic [DIVCLK_WIDTH-1:0]   D_ONE = DIVCLK_WIDTH'(1);
  localparam logic [INTCOUNT_WIDTH-1:0] I_ONE = INTCOUNT_WIDTH'(1);

  logic                      run;
  logic [DIVCLK_WIDTH-1:0]   div_cnt;
  logic                      dir_up;
  logic [W-1:0]              period_act;
  logic [N_CH*W-1:0]         cmp_act;
  logic [1:0]                mode_act;
  logic [INTCOUNT_WIDTH-1:0] evt_cnt;
  logic [N_CH-1:0]           raw_q;
  logic [N_CH-1:0]           raw_nxt;

  logic         tick, min_evt, max_evt, reload_hit, reload, evt_inc, dir_nxt;
  logic [W-1:0] carrier_nxt;

  assign run     = (pwm_on == PWM_ON);
  assign tick    = (div_cnt == clkdiv);
  assign min_evt = (carrier == '0);
  assign max_evt = (carrier == period_act);

  always_comb begin
    reload_hit = 1'b0;
    case (mask_mode)
      NO_MASK:     reload_hit = 1'b1;
      MIN_MASK:    reload_hit = min_evt;
      MAX_MASK:    reload_hit = max_evt;
      MINMAX_MASK: reload_hit = min_evt | max_evt;
    endcase
  end

  assign reload  = tick & reload_hit;
  // NO_MASK reloads every tick, so the irq divider counts carrier minima there instead
  assign evt_inc = (mask_mode == NO_MASK) ? (tick & min_evt) : reload;

  always_comb begin
    carrier_nxt = carrier;
    dir_nxt     = 1'b1;
    case (mode_act)
      COUNT_DOWN: carrier_nxt = min_evt ? period_act : carrier - C_ONE;
      COUNT_UPDOWN: begin
        if (period_act == '0) begin
          carrier_nxt = '0;
        end else if (dir_up) begin
          if (carrier >= period_act) begin
            carrier_nxt = carrier - C_ONE;
            dir_nxt     = 1'b0;
          end else begin
            carrier_nxt = carrier + C_ONE;
          end
        end else if (min_evt) begin
          carrier_nxt = C_ONE;
        end else begin
          carrier_nxt = carrier - C_ONE;
          dir_nxt     = 1'b0;
        end
      end
      default: carrier_nxt = (carrier >= period_act) ? '0 : carrier + C_ONE;
    endcase
  end

  always_comb begin
    raw_nxt = '0;
    for (int k = 0; k < N_CH; k++) raw_nxt[k] = (carrier < cmp_act[k*W +: W]);
  end

  // Carrier timebase and shadow-to-active reload; the carrier step uses the pre-reload values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      carrier    <= '0;
      dir_up     <= 1'b1;
      period_act <= '0;
      cmp_act    <= '0;
      mode_act   <= COUNT_UP;
    end else if (!run) begin
      div_cnt    <= '0;
      carrier    <= '0;
      dir_up     <= 1'b1;
      period_act <= '0;
      cmp_act    <= '0;
      mode_act   <= COUNT_UP;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + D_ONE;
      if (tick) begin
        carrier <= carrier_nxt;
        dir_up  <= dir_nxt;
      end
      if (reload) begin
        period_act <= period;
        cmp_act    <= compare;
        mode_act   <= count_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt  <= '0;
      load_evt <= 1'b0;
      irq      <= 1'b0;
    end else if (!run) begin
      evt_cnt  <= '0;
      load_evt <= 1'b0;
      irq      <= 1'b0;
    end else begin
      load_evt <= reload;
      irq      <= 1'b0;
      if (int_on != INT_ON) begin
        evt_cnt <= '0;
      end else if (evt_inc) begin
        if (evt_cnt == int_count) begin
          evt_cnt <= '0;
          irq     <= 1'b1;
        end else begin
          evt_cnt <= evt_cnt + I_ONE;
        end
      end
    end
  end

`ifdef CPWM_DEADTIME_EN
  localparam logic [DTCOUNT_WIDTH-1:0] DT_ONE = DTCOUNT_WIDTH'(1);

  logic [N_CH-1:0]                    raw_d;
  logic [N_CH-1:0][DTCOUNT_WIDTH-1:0] dt_cnt;

  // Any raw edge blanks both sides and restarts the count; the new side asserts on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= '0;
      raw_d  <= '0;
      dt_cnt <= '0;
      pwm_h  <= '0;
      pwm_l  <= '0;
    end else if (!run) begin
      raw_q  <= '0;
      raw_d  <= '0;
      dt_cnt <= '0;
      pwm_h  <= '0;
      pwm_l  <= '0;
    end else begin
      raw_q <= raw_nxt;
      raw_d <= raw_q;
      for (int k = 0; k < N_CH; k++) begin
        if (raw_q[k] != raw_d[k]) begin
          dt_cnt[k] <= deadtime;
          pwm_h[k]  <= (deadtime == '0) & raw_q[k];
          pwm_l[k]  <= (deadtime == '0) & ~raw_q[k];
        end else if (dt_cnt[k] > DT_ONE) begin
          dt_cnt[k] <= dt_cnt[k] - DT_ONE;
          pwm_h[k]  <= 1'b0;
          pwm_l[k]  <= 1'b0;
        end else begin
          dt_cnt[k] <= '0;
          pwm_h[k]  <= raw_q[k];
          pwm_l[k]  <= ~raw_q[k];
        end
      end
    end
  end
`else
  logic dt_unused;
  assign dt_unused = ^deadtime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= '0;
      pwm_h <= '0;
      pwm_l <= '0;
    end else if (!run) begin
      raw_q <= '0;
      pwm_h <= '0;
      pwm_l <= '0;
    end else begin
      raw_q <= raw_nxt;
      pwm_h <= raw_q;
      pwm_l <= ~raw_q;
    end
  end
`endif

endmodule

// File: tb/tb_cpwm_multich.sv
// Scoreboard bench for cpwm_multich: a per-clock reference model queues expected outputs,
// a negedge monitor pops and compares them; a few directed window counts check duty/event rates.
module tb_cpwm_multich;
  localparam int N  = 3;
  localparam int DW = 5;
  localparam int W  = 16;
  localparam int TW = 8;
  localparam int IW = 3;
  localparam int AGE_MAX = 1000;
`ifdef CPWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_on = 1'b0;
  logic          int_on = 1'b0;
  logic [1:0]    count_mode = 2'b00;
  logic [1:0]    mask_mode = 2'b00;
  logic [DW-1:0] clkdiv = '0;
  logic [W-1:0]  period = '0;
  logic [N*W-1:0] compare = '0;
  logic [TW-1:0] deadtime = '0;
  logic [IW-1:0] int_count = '0;
  logic [W-1:0]  carrier;
  logic [N-1:0]  pwm_h, pwm_l;
  logic          load_evt, irq;

  cpwm_multich dut (
    .clk(clk), .rst(rst), .pwm_on(pwm_on), .int_on(int_on),
    .count_mode(count_mode), .mask_mode(mask_mode), .clkdiv(clkdiv),
    .period(period), .compare(compare), .deadtime(deadtime), .int_count(int_count),
    .carrier(carrier), .pwm_h(pwm_h), .pwm_l(pwm_l), .load_evt(load_evt), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] car;
    logic [N-1:0] h;
    logic [N-1:0] l;
    logic         ld;
    logic         irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state, plain integers
  int   m_div, m_car, m_p, m_mode, m_evt;
  bit   m_up;
  int   m_cmp[N];
  bit   m_raw[N];
  int   m_age[N];
  exp_t m_out;

  task automatic model_clear();
    m_div = 0; m_car = 0; m_p = 0; m_mode = 0; m_evt = 0; m_up = 1'b1;
    for (int k = 0; k < N; k++) begin
      m_cmp[k] = 0; m_raw[k] = 1'b0; m_age[k] = AGE_MAX;
    end
    m_out.car = '0; m_out.h = '0; m_out.l = '0; m_out.ld = 1'b0; m_out.irq = 1'b0;
  endtask

  task automatic model_step();
    bit nraw;
    bit tick, mn, mx, rl, inc;
    int dtv;
    if (rst || !pwm_on) begin
      model_clear();
      return;
    end
    dtv = DT_EN ? int'(deadtime) : 0;
    for (int k = 0; k < N; k++) begin
      nraw = (m_car < m_cmp[k]);
      m_out.h[k] = m_raw[k] && (m_age[k] >= dtv);
      m_out.l[k] = !m_raw[k] && (m_age[k] >= dtv);
      if (nraw != m_raw[k]) m_age[k] = 0;
      else if (m_age[k] < AGE_MAX) m_age[k] = m_age[k] + 1;
      m_raw[k] = nraw;
    end
    tick = (m_div == int'(clkdiv));
    m_div = tick ? 0 : (m_div + 1) % 32;
    m_out.ld = 1'b0;
    m_out.irq = 1'b0;
    if (tick) begin
      mn = (m_car == 0);
      mx = (m_car == m_p);
      case (int'(mask_mode))
        0: rl = 1'b1;
        1: rl = mn;
        2: rl = mx;
        default: rl = mn || mx;
      endcase
      inc = (mask_mode == 2'b00) ? mn : rl;
      if (m_mode == 1) begin
        m_car = (m_car == 0) ? m_p : m_car - 1;
        m_up = 1'b1;
      end else if (m_mode == 2) begin
        if (m_p == 0) begin
          m_car = 0; m_up = 1'b1;
        end else if (m_up && m_car < m_p) m_car = m_car + 1;
        else if (m_up) begin
          m_car = m_car - 1; m_up = 1'b0;
        end else if (m_car == 0) begin
          m_car = 1; m_up = 1'b1;
        end else m_car = m_car - 1;
      end else begin
        m_car = (m_car >= m_p) ? 0 : m_car + 1;
        m_up = 1'b1;
      end
      if (rl) begin
        m_p = int'(period);
        m_mode = int'(count_mode);
        for (int k = 0; k < N; k++) m_cmp[k] = int'(compare[k*W +: W]);
      end
      m_out.ld = rl;
      if (int_on && inc) begin
        if (m_evt == int'(int_count)) begin
          m_evt = 0; m_out.irq = 1'b1;
        end else m_evt = (m_evt + 1) % 8;
      end
    end
    if (!int_on) m_evt = 0;
    m_out.car = W'(m_car);
  endtask

  // One clock: model the edge just taken, optionally hit rst asynchronously mid-cycle, queue result
  task automatic cycle(input bit async_rst = 1'b0);
    @(posedge clk);
    #1;
    model_step();
    if (async_rst) begin
      rst = 1'b1;
      model_clear();
    end
    exp_q.push_back(m_out);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (carrier !== e.car || pwm_h !== e.h || pwm_l !== e.l || load_evt !== e.ld || irq !== e.irq) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got car=%0d h=%b l=%b ld=%b irq=%b, want car=%0d h=%b l=%b ld=%b irq=%b",
                   $time, carrier, pwm_h, pwm_l, load_evt, irq, e.car, e.h, e.l, e.ld, e.irq);
        end
        n_vec++;
        if ((pwm_h & pwm_l) !== '0) begin
          n_bad++;
          $display("FAIL overlap t=%0t: got h&l=%b, want 000", $time, pwm_h & pwm_l);
        end
      end
    end
  end

  task automatic restart();
    pwm_on = 1'b0;
    cycle();
    pwm_on = 1'b1;
  endtask

  initial begin : stimulus
    int cnt;
    int r;
    model_clear();
    repeat (3) cycle();
    rst = 1'b0;

    // UP, P=4, clkdiv=1: ch0 duty 4/10, ch1 cmp=0 always low, ch2 cmp>P always high
    clkdiv = 5'd1; count_mode = 2'b00; mask_mode = 2'b00; period = 16'd4;
    compare = {16'd5, 16'd0, 16'd2}; deadtime = '0; int_on = 1'b0; int_count = '0;
    pwm_on = 1'b1;
    repeat (12) cycle();
    cnt = 0;
    repeat (20) begin
      cycle();
      cnt += int'(pwm_h[0]);
    end
    n_vec++;
    if (cnt != 8) begin
      n_bad++;
      $display("FAIL duty_h0: got %0d high cycles in 20, want 8", cnt);
    end

    // UPDOWN, P=3, clkdiv=0, MINMAX: reload every 3 ticks
    pwm_on = 1'b0; cycle();
    clkdiv = '0; count_mode = 2'b10; mask_mode = 2'b11; period = 16'd3;
    compare = {16'd1, 16'd3, 16'd2};
    pwm_on = 1'b1;
    repeat (10) cycle();
    cnt = 0;
    repeat (12) begin
      cycle();
      cnt += int'(load_evt);
    end
    n_vec++;
    if (cnt != 4) begin
      n_bad++;
      $display("FAIL load_rate: got %0d load_evt in 12, want 4", cnt);
    end

    // Dead time 5 on a 50% carrier: both sides low 5 cycles per raw edge
    pwm_on = 1'b0; cycle();
    count_mode = 2'b00; mask_mode = 2'b01; period = 16'd10;
    compare = {16'd5, 16'd5, 16'd5}; deadtime = 8'd5;
    pwm_on = 1'b1;
    repeat (30) cycle();
    cnt = 0;
    repeat (11) begin
      cycle();
      cnt += int'(!pwm_h[0] && !pwm_l[0]);
    end
    n_vec++;
    if (cnt != (DT_EN ? 10 : 0)) begin
      n_bad++;
      $display("FAIL deadband: got %0d blanked cycles in 11, want %0d", cnt, DT_EN ? 10 : 0);
    end

    // MIN_MASK compare change mid-period, then irq every 3rd max event, then irq off
    pwm_on = 1'b0; cycle();
    deadtime = '0; period = 16'd9; compare = {16'd2, 16'd2, 16'd2}; mask_mode = 2'b01;
    pwm_on = 1'b1;
    repeat (14) cycle();
    compare = {16'd6, 16'd6, 16'd6};
    repeat (25) cycle();
    mask_mode = 2'b10; int_on = 1'b1; int_count = 3'd2;
    repeat (70) cycle();
    int_on = 1'b0;
    repeat (20) cycle();

    // Async reset and pwm_on drop mid-period, each followed by a restart from 0
    cycle(1'b1);
    cycle();
    rst = 1'b0;
    repeat (15) cycle();
    pwm_on = 1'b0; cycle();
    pwm_on = 1'b1;
    repeat (15) cycle();

    for (int s = 0; s < 25; s++) begin
      pwm_on = 1'b0; cycle();
      clkdiv = DW'($urandom_range(0, 2));
      period = W'($urandom_range(0, 7));
      for (int k = 0; k < N; k++) compare[k*W +: W] = W'($urandom_range(0, 9));
      count_mode = 2'($urandom_range(0, 3));
      mask_mode = 2'($urandom_range(0, 3));
      deadtime = TW'($urandom_range(0, 6));
      int_on = 1'($urandom_range(0, 1));
      int_count = IW'($urandom_range(0, 7));
      pwm_on = 1'b1;
      for (int c = 0; c < 120; c++) begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          cycle(1'b1);
          cycle();
          rst = 1'b0;
        end else if (r < 4) begin
          restart();
        end else if (r < 14) begin
          case ($urandom_range(0, 6))
            0: period = W'($urandom_range(0, 7));
            1: compare[W*$urandom_range(0, N-1) +: W] = W'($urandom_range(0, 9));
            2: count_mode = 2'($urandom_range(0, 3));
            3: mask_mode = 2'($urandom_range(0, 3));
            4: int_count = IW'($urandom_range(0, 7));
            5: int_on = ~int_on;
            default: clkdiv = DW'($urandom_range(0, 2));
          endcase
          cycle();
        end else begin
          cycle();
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
